// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative signed 32x32 multiply and divide, one bit per cycle.
// Works on operand magnitudes in CALC and applies the sign fix-up in FIX.
module alu_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  control_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo,
  output logic        div_by_zero,
  output logic        illegal
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic [31:0] a_reg, b_reg;
  logic [63:0] p;
  logic        legal;
  logic [31:0] a_mag_in, b_mag_in, ma, mb, q_fix, r_fix;
  logic [32:0] mul_sum, div_t;
  logic [63:0] p_next, prod;
  always_comb begin
    legal    = control_in == 4'd4 || control_in == 4'd5;
    a_mag_in = a[31] ? -a : a;
    b_mag_in = b[31] ? -b : b;
    ma       = a_reg[31] ? -a_reg : a_reg;
    mb       = b_reg[31] ? -b_reg : b_reg;
    mul_sum  = {1'b0, p[63:32]} + (p[0] ? {1'b0, ma} : 33'd0);
    div_t    = {p[63:32], p[31]} - {1'b0, mb};
    p_next   = is_div ? (div_t[32] ? {p[62:0], 1'b0} : {div_t[31:0], p[30:0], 1'b1})
                      : {mul_sum, p[31:1]};
    prod     = (a_reg[31] ^ b_reg[31]) ? -p : p;
    q_fix    = (a_reg[31] ^ b_reg[31]) ? -p[31:0] : p[31:0];
    r_fix    = a_reg[31] ? -p[63:32] : p[63:32];
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      p           <= '0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      illegal <= state == IDLE && start && !flush && !legal;
      if (flush && state != IDLE) state <= IDLE;
      else case (state)
        IDLE: if (start && legal && !flush) begin
          state  <= CALC;
          cnt    <= '0;
          is_div <= !control_in[0];
          a_reg  <= a;
          b_reg  <= b;
          p      <= {32'd0, control_in[0] ? b_mag_in : a_mag_in};
        end
        CALC: if (is_div && b_reg == '0) begin
          state       <= DONE;
          result_hi   <= a_reg;
          result_lo   <= '1;
          div_by_zero <= 1'b1;
        end else begin
          p   <= p_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          state       <= DONE;
          result_hi   <= is_div ? r_fix : prod[63:32];
          result_lo   <= is_div ? q_fix : prod[31:0];
          div_by_zero <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors plus busy-start, illegal, flush and reset sequences.
module tb_alu_muldiv;
  logic        clk = 0, rst_n = 0, start = 0, flush = 0;
  logic [3:0]  control_in = 0;
  logic [31:0] a = 0, b = 0;
  logic        busy, done, div_by_zero, illegal;
  logic [31:0] result_hi, result_lo;
  int n_cmp = 0, n_err = 0;

  alu_muldiv dut (.clk(clk), .rst_n(rst_n), .start(start), .control_in(control_in),
    .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .result_hi(result_hi),
    .result_lo(result_lo), .div_by_zero(div_by_zero), .illegal(illegal));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // lat = number of edges after the accepting edge until done is seen high
  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                        output int lat);
    hi = 'x; lo = 'x; dbz = 'x; lat = -1;
    @(negedge clk);
    start = 1; control_in = op; a = av; b = bv;
    @(posedge clk); #1;
    start = 0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i; hi = result_hi; lo = result_lo; dbz = div_by_zero;
      end
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs[12];
  logic [31:0] hi, lo;
  logic dbz;
  int lat, nd;

  initial begin
    vecs[0]  = '{4'd5, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[1]  = '{4'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[2]  = '{4'd4, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 33};
    vecs[3]  = '{4'd4, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1};
    vecs[4]  = '{4'd4, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
    vecs[5]  = '{4'd5, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0, 33};
    vecs[6]  = '{4'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'd1,        1'b0, 33};
    vecs[7]  = '{4'd5, 32'h00010000, 32'h00010000, 32'd1,        32'h0,        1'b0, 33};
    vecs[8]  = '{4'd4, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
    vecs[9]  = '{4'd4, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        1'b0, 33};
    vecs[10] = '{4'd5, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h0,        32'd30,       1'b0, 33};
    vecs[11] = '{4'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_hi", result_hi, 0);
    chk("rst_lo", result_lo, 0);
    chk("rst_dbz", {31'd0, div_by_zero}, 0);
    chk("rst_illegal", {31'd0, illegal}, 0);
    @(negedge clk) rst_n = 1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dbz, lat);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_dbz", i), {31'd0, dbz}, {31'd0, vecs[i].dbz});
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
    end

    // start while busy: the mul must be ignored, one done from the div
    @(negedge clk);
    start = 1; control_in = 4; a = 100; b = 7;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_accept", {31'd0, busy}, 1);
    repeat (9) @(negedge clk);
    start = 1; control_in = 5; a = 2; b = 2;
    @(posedge clk); #1;
    start = 0;
    chk("busy_start_illegal", {31'd0, illegal}, 0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) begin nd++; hi = result_hi; lo = result_lo; end
    end
    chk("busy_done_count", nd, 1);
    chk("busy_lo", lo, 14);
    chk("busy_hi", hi, 2);

    // illegal code
    @(negedge clk);
    start = 1; control_in = 2; a = 1; b = 1;
    @(posedge clk); #1;
    start = 0;
    chk("ill_pulse", {31'd0, illegal}, 1);
    chk("ill_busy", {31'd0, busy}, 0);
    nd = 0;
    @(posedge clk); #1;
    chk("ill_pulse_end", {31'd0, illegal}, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("ill_no_activity", nd, 0);

    // flush at cycle 15 of a mul
    @(negedge clk);
    start = 1; control_in = 5; a = 3; b = 3;
    @(posedge clk); #1;
    start = 0;
    repeat (14) @(posedge clk);
    @(negedge clk) flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_busy", {31'd0, busy}, 0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("flush_no_done", nd, 0);
    chk("flush_hi_held", result_hi, 2);
    chk("flush_lo_held", result_lo, 14);

    // reset at cycle 15 of a mul, then accept on first edge after release
    @(negedge clk);
    start = 1; control_in = 5; a = 3; b = 3;
    @(posedge clk); #1;
    start = 0;
    repeat (14) @(posedge clk);
    @(negedge clk) rst_n = 0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_lo", result_lo, 0);
    chk("arst_hi", result_hi, 0);
    @(negedge clk);
    rst_n = 1; start = 1; control_in = 5; a = 2; b = 3;
    @(posedge clk); #1;
    start = 0;
    chk("post_rst_accept", {31'd0, busy}, 1);
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; lo = result_lo; hi = result_hi; end
    end
    chk("post_rst_lat", lat, 33);
    chk("post_rst_lo", lo, 6);
    chk("post_rst_hi", hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
